// File: rtl/hbridge_pkg.sv
// Shared definitions for the H-bridge drive controller.
// Holds the controller state encoding, the IN1..IN4 pin patterns for each
// drive direction and the switch-to-direction decode used by the top level.
package hbridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam logic [3:0] DIR_FWD   = 4'b0110;
    localparam logic [3:0] DIR_RIGHT = 4'b0101;
    localparam logic [3:0] DIR_LEFT  = 4'b1010;
    localparam logic [3:0] DIR_REV   = 4'b1001;
    localparam logic [3:0] DIR_OFF   = 4'b0000;

    // sel is switch bits [3:1]: sel[0]=sw[1], sel[1]=sw[2], sel[2]=sw[3].
    // The checks are ordered, so the first matching pattern wins.
    function automatic logic [3:0] decodeDir(input logic [2:0] sel);
        logic [3:0] dir;
        if (sel == 3'b001) begin
            dir = DIR_FWD;
        end else if (sel[1] && !sel[2]) begin
            dir = DIR_RIGHT;
        end else if (sel[2]) begin
            dir = DIR_LEFT;
        end else begin
            dir = DIR_REV;
        end
        return dir;
    endfunction

endpackage

// File: rtl/hbridge_drive_ctrl_duty_ramp.sv
// Duty slew limiter for the H-bridge drive controller.
// A prescaler produces one step every RAMP_DIV enabled clocks. On each step
// the duty moves toward the target by RAMP_STEP. When the remaining gap is
// smaller than one step it lands exactly on the target, so it never
// overshoots or wraps.
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   enable_i  ramp is allowed to advance this clock
//   clear_i   force duty and prescaler to zero (wins over enable_i)
//   target_i  duty value to slew toward
//   duty_o    current registered duty
module duty_ramp #(
    parameter int DUTY_W    = 12,
    parameter int RAMP_DIV  = 1000,
    parameter int RAMP_STEP = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic [DUTY_W-1:0] target_i,
    output logic [DUTY_W-1:0] duty_o
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(RAMP_STEP);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] gap;

    // Prescaler and saturating step toward the target. The gap is computed
    // in the direction of travel, so it never goes negative.
    always_comb begin
        div_d  = div_q;
        duty_d = duty_q;
        gap    = '0;
        if (clear_i) begin
            div_d  = '0;
            duty_d = '0;
        end else if (enable_i) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (duty_q < target_i) begin
                    gap    = target_i - duty_q;
                    duty_d = (gap < STEP) ? target_i : duty_q + STEP;
                end else if (duty_q > target_i) begin
                    gap    = duty_q - target_i;
                    duty_d = (gap < STEP) ? target_i : duty_q - STEP;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Ramp state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            duty_q <= '0;
        end else begin
            div_q  <= div_d;
            duty_q <= duty_d;
        end
    end

    assign duty_o = duty_q;

endmodule

// File: rtl/hbridge_drive_ctrl.sv
// H-bridge drive controller.
// Synchronises the switch bank and the overcurrent flags, then runs an
// IDLE/DEAD/RUN/FAULT state machine. Every drive direction is entered through
// a dead-time interval with all bridge inputs low. The duty output slews
// toward the switch magnitude. Any overcurrent flag latches a fault that is
// only released after the flags have stayed clear for a hold time.
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   sw_i      switches: [0] run, [3:1] direction, [7:4] duty magnitude
//   oc_i      per-channel overcurrent flags, active high, asynchronous
//   pulse_i   PWM waveform from the pwm generator
//   in_out_o  H-bridge IN1..IN4, registered
//   en_o      per-channel bridge enables (pulse gated by RUN)
//   duty_o    ramped duty, registered
//   fault_o   latched overcurrent fault, registered
module hbridge_drive_ctrl
    import hbridge_pkg::*;
#(
    parameter int CH           = 2,
    parameter int DUTY_W       = 12,
    parameter int DEADTIME_CYC = 50,
    parameter int RAMP_DIV     = 1000,
    parameter int RAMP_STEP    = 16,
    parameter int OC_HOLD_CYC  = 500000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        sw_i,
    input  logic [CH-1:0]     oc_i,
    input  logic              pulse_i,
    output logic [3:0]        in_out_o,
    output logic [CH-1:0]     en_o,
    output logic [DUTY_W-1:0] duty_o,
    output logic              fault_o
);

    localparam int DEAD_W = $clog2(DEADTIME_CYC + 1);
    localparam int HOLD_W = $clog2(OC_HOLD_CYC + 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OC_HOLD_CYC - 1);

    logic [7:0]        sw_meta_q, sw_s_q;
    logic [CH-1:0]     oc_meta_q, oc_s_q;

    state_e            state_q, state_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]        in_out_q, in_out_d;
    logic              fault_q, fault_d;

    logic              run_req;
    logic              oc_any;
    logic [3:0]        dir_req;
    logic [DUTY_W-1:0] duty_tgt;

    // Two-flop synchronisers for the switch bank and the overcurrent flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
            oc_meta_q <= '0;
            oc_s_q    <= '0;
        end else begin
            sw_meta_q <= sw_i;
            sw_s_q    <= sw_meta_q;
            oc_meta_q <= oc_i;
            oc_s_q    <= oc_meta_q;
        end
    end

    assign run_req  = sw_s_q[0];
    assign oc_any   = |oc_s_q;
    assign dir_req  = decodeDir(sw_s_q[3:1]);
    assign duty_tgt = {sw_s_q[7:4], {(DUTY_W-4){1'b0}}};

    // Next-state logic. Overcurrent always has priority, then run disable,
    // then direction change. Every path into RUN goes through DEAD, so
    // the bridge always sees the full dead-time with all inputs low.
    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        hold_cnt_d = hold_cnt_q;
        in_out_d   = in_out_q;
        fault_d    = fault_q;
        unique case (state_q)
            IDLE: begin
                in_out_d = DIR_OFF;
                if (run_req && !oc_any) begin
                    state_d    = DEAD;
                    dead_cnt_d = DEAD_LOAD;
                end
            end
            DEAD: begin
                in_out_d = DIR_OFF;
                if (oc_any) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    hold_cnt_d = HOLD_LOAD;
                end else if (!run_req) begin
                    state_d = IDLE;
                end else if (dead_cnt_q == '0) begin
                    state_d  = RUN;
                    in_out_d = dir_req;
                end else begin
                    dead_cnt_d = dead_cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (oc_any) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    hold_cnt_d = HOLD_LOAD;
                    in_out_d   = DIR_OFF;
                end else if (!run_req) begin
                    state_d  = IDLE;
                    in_out_d = DIR_OFF;
                end else if (dir_req != in_out_q) begin
                    state_d    = DEAD;
                    dead_cnt_d = DEAD_LOAD;
                    in_out_d   = DIR_OFF;
                end
            end
            FAULT: begin
                in_out_d = DIR_OFF;
                fault_d  = 1'b1;
                if (oc_any) begin
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                in_out_d = DIR_OFF;
                fault_d  = 1'b0;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            dead_cnt_q <= '0;
            hold_cnt_q <= '0;
            in_out_q   <= DIR_OFF;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dead_cnt_q <= dead_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            in_out_q   <= in_out_d;
            fault_q    <= fault_d;
        end
    end

    // Clearing on the next state zeroes duty on the same edge that
    // leaves RUN, rather than one clock later.
    duty_ramp #(
        .DUTY_W    (DUTY_W),
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP)
    ) u_duty_ramp (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (state_q == RUN),
        .clear_i  (state_d != RUN),
        .target_i (duty_tgt),
        .duty_o   (duty_o)
    );

    assign in_out_o = in_out_q;
    assign fault_o  = fault_q;
    assign en_o     = (state_q == RUN) ? {CH{pulse_i}} : '0;

endmodule

// File: tb/tb_hbridge_drive_ctrl.sv
// Directed testbench for hbridge_drive_ctrl with small parameters so that
// dead-time, ramp and fault hold intervals are only a few clocks long.
module tb_hbridge_drive_ctrl;

    logic        clk;
    logic        rstN;
    logic [7:0]  sw;
    logic [1:0]  oc;
    logic        pulse;
    logic [3:0]  inOut;
    logic [1:0]  en;
    logic [11:0] duty;
    logic        fault;

    int checks;
    int errors;

    hbridge_drive_ctrl #(
        .CH           (2),
        .DUTY_W       (12),
        .DEADTIME_CYC (4),
        .RAMP_DIV     (2),
        .RAMP_STEP    (256),
        .OC_HOLD_CYC  (8)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .sw_i     (sw),
        .oc_i     (oc),
        .pulse_i  (pulse),
        .in_out_o (inOut),
        .en_o     (en),
        .duty_o   (duty),
        .fault_o  (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] swV, input logic [1:0] ocV, input logic pulseV);
        sw    = swV;
        oc    = ocV;
        pulse = pulseV;
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with all switches high and pulse high.
        rstN = 1'b0;
        applyStimulus(8'hFF, 2'b00, 1'b1);
        waitCycles(3);
        checkOutput("rstInOut", 32'(inOut), 32'h0);
        checkOutput("rstEn",    32'(en),    32'h0);
        checkOutput("rstDuty",  32'(duty),  32'h0);
        checkOutput("rstFault", 32'(fault), 32'h0);
        rstN = 1'b1;
        waitCycles(1);
        checkOutput("relInOut", 32'(inOut), 32'h0);
        checkOutput("relEn",    32'(en),    32'h0);
        checkOutput("relFault", 32'(fault), 32'h0);

        // Clean restart with switches off.
        rstN = 1'b0;
        applyStimulus(8'h00, 2'b00, 1'b1);
        waitCycles(2);
        rstN = 1'b1;

        // Start-up forward at full magnitude.
        applyStimulus(8'hF3, 2'b00, 1'b1);
        waitCycles(6);
        checkOutput("startDeadInOut", 32'(inOut), 32'h0);
        checkOutput("startDeadEn",    32'(en),    32'h0);
        waitCycles(1);
        checkOutput("startRunInOut", 32'(inOut), 32'h6);
        checkOutput("startRunEn",    32'(en),    32'h3);
        checkOutput("startDuty0",    32'(duty),  32'h0);
        waitCycles(2);
        checkOutput("startDuty1", 32'(duty), 32'h100);
        waitCycles(2);
        checkOutput("startDuty2", 32'(duty), 32'h200);
        pulse = 1'b0;
        #1;
        checkOutput("pulseLowEn", 32'(en), 32'h0);
        pulse = 1'b1;
        waitCycles(26);
        checkOutput("startDutyTop", 32'(duty), 32'hF00);
        waitCycles(4);
        checkOutput("startDutySat", 32'(duty), 32'hF00);

        // Direction change forward -> left.
        applyStimulus(8'hF9, 2'b00, 1'b1);
        waitCycles(2);
        checkOutput("dirLatInOut", 32'(inOut), 32'h6);
        checkOutput("dirLatDuty",  32'(duty),  32'hF00);
        waitCycles(1);
        checkOutput("dirDeadInOut", 32'(inOut), 32'h0);
        checkOutput("dirDeadEn",    32'(en),    32'h0);
        checkOutput("dirDeadDuty",  32'(duty),  32'h0);
        waitCycles(3);
        checkOutput("dirDeadEndInOut", 32'(inOut), 32'h0);
        checkOutput("dirDeadEndEn",    32'(en),    32'h0);
        waitCycles(1);
        checkOutput("dirRunInOut", 32'(inOut), 32'hA);
        checkOutput("dirRunEn",    32'(en),    32'h3);
        checkOutput("dirRunDuty0", 32'(duty),  32'h0);
        waitCycles(2);
        checkOutput("dirRunDuty1", 32'(duty), 32'h100);
        waitCycles(28);
        checkOutput("dirRunDutyTop", 32'(duty), 32'hF00);

        // Ramp down to magnitude 1.
        applyStimulus(8'h19, 2'b00, 1'b1);
        waitCycles(2);
        checkOutput("downHold", 32'(duty), 32'hF00);
        waitCycles(2);
        checkOutput("downStep1", 32'(duty), 32'hE00);
        waitCycles(2);
        checkOutput("downStep2", 32'(duty), 32'hD00);
        waitCycles(22);
        checkOutput("downStep13", 32'(duty), 32'h200);
        waitCycles(2);
        checkOutput("downEnd", 32'(duty), 32'h100);
        waitCycles(4);
        checkOutput("downNoUnder", 32'(duty), 32'h100);

        // Ramp back up, then drop run mid-ramp.
        applyStimulus(8'hF9, 2'b00, 1'b1);
        waitCycles(8);
        checkOutput("upMid", 32'(duty), 32'h400);
        applyStimulus(8'hF8, 2'b00, 1'b1);
        waitCycles(2);
        checkOutput("offLatDuty",  32'(duty),  32'h500);
        checkOutput("offLatInOut", 32'(inOut), 32'hA);
        waitCycles(1);
        checkOutput("offDuty",  32'(duty),  32'h0);
        checkOutput("offInOut", 32'(inOut), 32'h0);
        checkOutput("offEn",    32'(en),    32'h0);

        // Restart left, then overcurrent on channel 0 for 3 clocks.
        applyStimulus(8'hF9, 2'b00, 1'b1);
        waitCycles(7);
        checkOutput("reRunInOut", 32'(inOut), 32'hA);
        applyStimulus(8'hF9, 2'b01, 1'b1);
        waitCycles(2);
        checkOutput("ocLatInOut", 32'(inOut), 32'hA);
        checkOutput("ocLatFault", 32'(fault), 32'h0);
        waitCycles(1);
        checkOutput("ocFault", 32'(fault), 32'h1);
        checkOutput("ocInOut", 32'(inOut), 32'h0);
        checkOutput("ocEn",    32'(en),    32'h0);
        checkOutput("ocDuty",  32'(duty),  32'h0);
        applyStimulus(8'hF9, 2'b00, 1'b1);
        waitCycles(9);
        checkOutput("ocHoldFault", 32'(fault), 32'h1);
        waitCycles(1);
        checkOutput("ocClearFault", 32'(fault), 32'h0);
        checkOutput("ocClearInOut", 32'(inOut), 32'h0);
        waitCycles(4);
        checkOutput("ocDeadInOut", 32'(inOut), 32'h0);
        waitCycles(1);
        checkOutput("ocRunInOut", 32'(inOut), 32'hA);
        checkOutput("ocRunEn",    32'(en),    32'h3);

        // Overcurrent on channel 1 together with run disable: fault wins.
        applyStimulus(8'hF8, 2'b10, 1'b1);
        waitCycles(3);
        checkOutput("prioFault", 32'(fault), 32'h1);
        checkOutput("prioInOut", 32'(inOut), 32'h0);
        applyStimulus(8'hF8, 2'b00, 1'b1);
        waitCycles(10);
        checkOutput("prioClearFault", 32'(fault), 32'h0);
        waitCycles(7);
        checkOutput("prioIdleInOut", 32'(inOut), 32'h0);
        checkOutput("prioIdleEn",    32'(en),    32'h0);

        // Asynchronous reset in the middle of a forward ramp.
        applyStimulus(8'hF3, 2'b00, 1'b1);
        waitCycles(11);
        checkOutput("preRstInOut", 32'(inOut), 32'h6);
        checkOutput("preRstDuty",  32'(duty),  32'h200);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncRstInOut", 32'(inOut), 32'h0);
        checkOutput("asyncRstEn",    32'(en),    32'h0);
        checkOutput("asyncRstDuty",  32'(duty),  32'h0);
        checkOutput("asyncRstFault", 32'(fault), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
